// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO read-side stream drain.
// Optional statistics output is enabled with the FIFO_DRAIN_STATS_EN macro.
package fifo_drain_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } drain_state_e;

  localparam int DRAIN_BUF_DEPTH = 2;

  // Issue counter needs at least one bit even when a burst is a single beat.
  function automatic int issue_cnt_width(input int burst_len);
    return (burst_len <= 2) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/fifo_drain_skid_buf.sv
// Two-entry in-order buffer holding returned FIFO words (data plus last tag).
// Entry 0 is always the head; simultaneous push and pop keep occupancy unchanged.
module fifo_drain_skid_buf
  import fifo_drain_pkg::*;
#(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [1:0]    occ_o
);

  logic [DW-1:0] ent0_q, ent0_d;
  logic [DW-1:0] ent1_q, ent1_d;
  logic [1:0]    occ_q, occ_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case (occ_q)
      2'd0: begin
        if (push_i) begin
          ent0_d = push_data_i;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push_i && pop_i) begin
          ent0_d = push_data_i;
        end else if (push_i) begin
          ent1_d = push_data_i;
          occ_d  = 2'd2;
        end else if (pop_i) begin
          occ_d  = 2'd0;
        end
      end
      default: begin
        if (pop_i) begin
          ent0_d = ent1_q;
          if (push_i) ent1_d = push_data_i;
          else        occ_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  // The read-strobe credit check upstream makes this unreachable.
  assert property (@(posedge clk) disable iff (!reset)
    !(push_i && !pop_i && (occ_q == 2'(DRAIN_BUF_DEPTH))));

  assign head_o = ent0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a synchronous FIFO into a valid/ready stream framed in BURST_LEN-beat bursts.
// Define FIFO_DRAIN_STATS_EN to add the burst_count statistics output.
module fifo_stream_drain
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             drain_en,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             burst_active
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]      burst_count
`endif
);

  localparam int            CW       = issue_cnt_width(BURST_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

  drain_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          inflight_q, inflight_last_q;
  logic [1:0]    occ;
  logic [WIDTH:0] head;
  logic          pop;
  logic          last_issue;
  logic [2:0]    slots_after;

  // Stream handshake: a beat transfers on a rising edge where m_valid and m_ready
  // are both high; once m_valid is up, m_data/m_last hold until that transfer.
  assign pop     = m_valid && m_ready;
  assign m_valid = (occ != 2'd0);
  assign m_data  = head[WIDTH-1:0];
  assign m_last  = head[WIDTH];

  // Buffered words plus the one in flight, after this cycle's pop, must leave room.
  assign slots_after  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign burst_active = (state_q == BURST);
  assign fifo_rd_en   = burst_active && !fifo_empty && (slots_after < 3'(DRAIN_BUF_DEPTH));
  assign last_issue   = fifo_rd_en && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fifo_rd_en) cnt_d = last_issue ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE:    if (drain_en) state_d = BURST;
      BURST:   if (last_issue && !drain_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      inflight_q      <= fifo_rd_en;
      inflight_last_q <= last_issue;
    end
  end

  fifo_drain_skid_buf #(
    .DW(WIDTH + 1)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .push_i     (inflight_q),
    .push_data_i({inflight_last_q, fifo_rd_data}),
    .pop_i      (pop),
    .head_o     (head),
    .occ_o      (occ)
  );

`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] burst_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               burst_cnt_q <= 16'd0;
    else if (pop && m_last)   burst_cnt_q <= burst_cnt_q + 16'd1;
  end

  assign burst_count = burst_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Self-checking bench for fifo_stream_drain: a queue-backed FIFO model feeds the DUT,
// a scoreboard checks order and burst framing, plus a single-beat-burst instance.
module tb_fifo_stream_drain;

  localparam int W  = 32;
  localparam int BL = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         drain_en;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [W-1:0] fifo_rd_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         burst_active;

  logic         drain_en1;
  logic         fifo_empty1;
  logic         fifo_rd_en1;
  logic [W-1:0] fifo_rd_data1;
  logic         m_valid1;
  logic [W-1:0] m_data1;
  logic         m_last1;
  logic         burst_active1;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0]  burst_count;
  logic [15:0]  burst_count1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_stream_drain #(.WIDTH(W), .BURST_LEN(BL)) dut (
    .clk         (clk),
    .reset       (reset),
    .drain_en    (drain_en),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .burst_active(burst_active)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .burst_count (burst_count)
`endif
  );

  fifo_stream_drain #(.WIDTH(W), .BURST_LEN(1)) dut1 (
    .clk         (clk),
    .reset       (reset),
    .drain_en    (drain_en1),
    .fifo_empty  (fifo_empty1),
    .fifo_rd_en  (fifo_rd_en1),
    .fifo_rd_data(fifo_rd_data1),
    .m_valid     (m_valid1),
    .m_ready     (m_ready),
    .m_data      (m_data1),
    .m_last      (m_last1),
    .burst_active(burst_active1)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .burst_count (burst_count1)
`endif
  );

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- upstream FIFO model (shares the reset net) ----------------
  logic [W-1:0] fmem [0:255];
  int wr_ptr = 0;
  int rd_ptr;
  logic [W-1:0] exp_q[$];

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr       <= 0;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= fmem[rd_ptr[7:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Endless counting source for the single-beat-burst instance.
  logic [W-1:0] src1_cnt;
  assign drain_en1   = 1'b1;
  assign fifo_empty1 = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      src1_cnt      <= '0;
      fifo_rd_data1 <= '0;
    end else if (fifo_rd_en1) begin
      fifo_rd_data1 <= src1_cnt;
      src1_cnt      <= src1_cnt + 1;
    end
  end

  // ---------------- scoreboard / monitor (negedge sampling) ----------------
  int beats, obs_lasts, strobes;
  int first_strobe, first_beat, last_beat;
  logic         held_valid;
  logic [W-1:0] held_data;
  logic         held_last;
  logic [W-1:0] exp1;

  always @(negedge clk) begin
    if (!reset) begin
      beats = 0; obs_lasts = 0; strobes = 0;
      first_strobe = -1; first_beat = -1; last_beat = -1;
      held_valid = 1'b0; exp1 = '0;
      exp_q.delete();
    end else begin
      if (fifo_rd_en) begin
        if (first_strobe < 0) first_strobe = cyc;
        strobes++;
      end
      if (held_valid) begin
        chk("hold_data", m_data, held_data);
        chk("hold_last", m_last, held_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          chk("beat_data", m_data, exp_q.pop_front());
          chk("beat_last", m_last, ((beats % BL) == BL - 1) ? 1 : 0);
        end
        if (m_last) obs_lasts++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        beats++;
      end
      held_valid = m_valid && !m_ready;
      held_data  = m_data;
      held_last  = m_last;
      if (m_valid1 && m_ready) begin
        chk("bl1_data", m_data1, exp1);
        chk("bl1_last", m_last1, 1);
        exp1 = exp1 + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit rdy, input bit drn);
    @(posedge clk);
    #1;
    m_ready  = rdy;
    drain_en = drn;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit rnd, input int drop_after);
    for (int i = 0; i < n; i++)
      drive(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, strobes < drop_after);
  endtask

  task automatic push_word(input logic [W-1:0] d);
    fmem[wr_ptr[7:0]] = d;
    wr_ptr++;
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    drain_en = 1'b0;
    m_ready  = 1'b0;
    wr_ptr   = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int n_words;
    int drop_after;
    bit rnd_ready;
    int exp_beats;
    int exp_lasts;
    int exp_left;
    bit exp_active;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic all_active;

    vecs[0] = '{32, 1000, 1'b0, 32, 2,  0, 1'b1};  // full throughput, data 0..31
    vecs[1] = '{32, 1000, 1'b1, 32, 2,  0, 1'b1};  // random backpressure
    vecs[2] = '{40,    3, 1'b0, 16, 1, 24, 1'b0};  // drop after 3rd strobe
    vecs[3] = '{40,   16, 1'b1, 32, 2,  8, 1'b0};  // still high at the 16th strobe
    vecs[4] = '{40,   17, 1'b0, 32, 2,  8, 1'b0};
    vecs[5] = '{10, 1000, 1'b0, 10, 0,  0, 1'b1};  // partial burst, stalls on empty
    vecs[6] = '{48, 1000, 1'b1, 48, 3,  0, 1'b1};
    vecs[7] = '{ 0, 1000, 1'b0,  0, 0,  0, 1'b1};
    vecs[8] = '{ 5,    2, 1'b1,  5, 0,  0, 1'b1};

    reset    = 1'b1;
    drain_en = 1'b0;
    m_ready  = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_active", burst_active, 0);

    for (int v = 0; v < 9; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n_words; i++)
        push_word((v == 0) ? W'(i) : W'($urandom));
      m_ready  = 1'b1;
      drain_en = (vecs[v].drop_after > 0);
      run(300, vecs[v].rnd_ready, vecs[v].drop_after);
      settle();
      chk($sformatf("v%0d_beats", v), beats, vecs[v].exp_beats);
      chk($sformatf("v%0d_lasts", v), obs_lasts, vecs[v].exp_lasts);
      chk($sformatf("v%0d_left", v), wr_ptr - rd_ptr, vecs[v].exp_left);
      chk($sformatf("v%0d_active", v), burst_active, vecs[v].exp_active);
`ifdef FIFO_DRAIN_STATS_EN
      chk($sformatf("v%0d_burst_count", v), burst_count, vecs[v].exp_lasts);
`endif
      if (!vecs[v].rnd_ready && vecs[v].exp_beats > 0) begin
        chk($sformatf("v%0d_latency", v), first_beat - first_strobe, 2);
        chk($sformatf("v%0d_no_bubble", v), last_beat - first_beat, vecs[v].exp_beats - 1);
      end
    end

    // Empty stall: 10 words, then 6 more; last lands on the 16th word.
    do_reset();
    for (int i = 0; i < 10; i++) push_word(W'($urandom));
    m_ready    = 1'b1;
    drain_en   = 1'b1;
    all_active = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b1);
      settle();
      all_active &= burst_active;
    end
    chk("stall_beats_before", beats, 10);
    drive(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) push_word(W'($urandom));
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b1);
      settle();
      all_active &= burst_active;
    end
    chk("stall_beats_after", beats, 16);
    chk("stall_lasts", obs_lasts, 1);
    chk("stall_active", all_active, 1);

    // Backpressure: m_ready low for 5 cycles mid-burst.
    do_reset();
    for (int i = 0; i < 32; i++) push_word(W'($urandom));
    m_ready  = 1'b1;
    drain_en = 1'b1;
    for (int c = 0; c < 60; c++) begin
      drive(1'b1, 1'b1);
      settle();
      if (beats >= 5) break;
    end
    chk("bp_reached", (beats >= 5) ? 1 : 0, 1);
    for (int c = 0; c < 5; c++) drive(1'b0, 1'b1);
    settle();
    chk("bp_buffered", strobes - beats, 2);
    chk("bp_rd_en_low", fifo_rd_en, 0);
    run(80, 1'b0, 1000);
    settle();
    chk("bp_beats", beats, 32);
    chk("bp_strobes", strobes, 32);

    // Asynchronous reset mid-stream, then IDLE until drain_en returns.
    do_reset();
    for (int i = 0; i < 32; i++) push_word(W'($urandom));
    m_ready  = 1'b1;
    drain_en = 1'b1;
    run(10, 1'b0, 1000);
    #2;
    chk("pre_reset_valid", m_valid, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_m_last", m_last, 0);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    chk("mid_rst_active", burst_active, 0);
    do_reset();
    for (int i = 0; i < 5; i++) push_word(W'($urandom));
    m_ready = 1'b1;
    run(10, 1'b0, 0);
    settle();
    chk("post_rst_strobes", strobes, 0);
    chk("post_rst_active", burst_active, 0);
    run(20, 1'b0, 1000);
    settle();
    chk("post_rst_beats", beats, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_drain.md
# fifo_stream_drain

Read-side stage that sits directly downstream of the team's synchronous FIFO. It issues FIFO read strobes, absorbs the FIFO's one-cycle registered read latency, and re-presents the data as a valid/ready stream framed into fixed-length bursts. A `m_last` flag marks the final beat of each burst. Full throughput is one word per clock when the FIFO is non-empty and the sink is ready.

## Interface
Parameters:
- `WIDTH`, 32: data width; must match the upstream FIFO.
- `BURST_LEN`, 16: beats per burst, ≥1; `m_last` is asserted on every BURST_LEN-th beat.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `drain_en` in 1: permission to start bursts; sampled only at burst boundaries.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO read strobe; combinational from registered state and `fifo_empty`.
- `fifo_rd_data` in WIDTH: FIFO read data, valid the cycle after an accepted strobe.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: sink ready.
- `m_data` out WIDTH: output beat data.
- `m_last` out 1: final beat of a burst.
- `burst_active` out 1: high while FSM is in BURST.

## Operation
- Reset values: `m_valid`=0, `m_data`=0, `m_last`=0, `fifo_rd_en`=0, `burst_active`=0. FSM resets to IDLE; the issue counter, in-flight flag and buffer occupancy reset to 0.
- FSM states:
  - IDLE→BURST when `drain_en`=1.
  - BURST→BURST when the BURST_LEN-th read issues and `drain_en`=1.
  - BURST→IDLE when the BURST_LEN-th read issues and `drain_en`=0.
  - Dropping `drain_en` mid-burst does not stop the burst; it always completes all BURST_LEN reads.
- `fifo_rd_en` = (state==BURST) && !`fifo_empty` && (occ + inflight − pop < 2).
  - `pop` = `m_valid` && `m_ready`.
  - `occ` is the 2-entry buffer occupancy, 0..2.
  - `inflight` = 1 in the cycle after `fifo_rd_en`.
- Issue counter: width max(1, $clog2(BURST_LEN)). It increments per strobe and wraps to 0 after BURST_LEN−1.
- A strobe issued at count BURST_LEN−1 tags its word last=1. The tag travels with the data through the buffer; the buffer stores WIDTH+1 bits per entry.
- Buffer order is strict FIFO, head at `m_data`/`m_last`. Push (in-flight return) and pop in the same cycle are both honoured, and occ is unchanged.
- Buffer never overflows by construction; overflow is an assertion target.
- `m_data`/`m_last` hold stable while `m_valid`=1 and `m_ready`=0.
- Asynchronous reset mid-burst discards buffered and in-flight words, with no partial-burst completion. The FIFO shares the same reset net.

## Timing
- Strobe in cycle N → `fifo_rd_data` in N+1 → buffer write at the end of N+1 → `m_valid` in N+2. Latency is 2 cycles.
- With `m_ready` held at 1 and the FIFO non-empty, one beat is delivered per cycle, with no bubbles across burst boundaries when `drain_en`=1.
- `m_ready` low for K cycles: at most 2 words are buffered; reads stall within 1 cycle and resume the cycle `pop` occurs.
- `fifo_empty` rising mid-burst: strobes pause and the counter holds; the burst resumes when data returns, and `m_last` position is preserved.

## Configuration
- `FIFO_DRAIN_STATS_EN` defined: adds output `burst_count` [15:0].
  - Increments on each beat accepted with `m_last`=1 (`pop` && `m_last`).
  - Wraps at 0xFFFF→0; resets to 0.
- `FIFO_DRAIN_STATS_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `fifo_drain_pkg`: state enum {IDLE, BURST}; constant `DRAIN_BUF_DEPTH`=2; function for the issue counter width.
- Sub-module `fifo_drain_skid_buf`: 2-entry WIDTH+1 buffer with push/pop and occupancy output. The top level holds the FSM, issue counter, in-flight flag and read-strobe logic.

## Test plan
- **Reset:** assert `reset`=0 mid-stream → all outputs 0 immediately; after release, FSM is IDLE and `fifo_rd_en`=0 until `drain_en`=1.
- **Full throughput:** preload FIFO with 32 words 0..31, BURST_LEN=16, `drain_en`=1, `m_ready`=1 → beats 0..31 on 32 consecutive cycles starting 2 cycles after the first strobe; `m_last` on values 15 and 31.
- **Backpressure:** hold `m_ready`=0 for 5 cycles mid-burst → `fifo_rd_en` low after 2 words are buffered; no loss or duplication; order preserved.
- **Empty stall:** FIFO holds 10 words, BURST_LEN=16; push 6 more after 20 cycles → `m_last` lands on the 16th word; `burst_active` stays 1 throughout.
- **drain_en drop:** deassert `drain_en` after the 3rd strobe → the burst completes 16 beats, then IDLE with no further strobes while the FIFO is non-empty.
- **Stats (with `FIFO_DRAIN_STATS_EN`):** 3 bursts complete → `burst_count`=3; with BURST_LEN=1, `m_last` is asserted on every beat.
